// File: rtl/inst_fetch_unit.sv
// Instruction-fetch initiator: owns the PC, drives the ROM read port, hands instructions to decode
// over valid/ready, applies redirects, and traps misaligned/out-of-range fetch addresses.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0040_0000,
  parameter logic [31:0] ROM_BASE_PC    = 32'h0040_0000,
  parameter int          ROM_ADDR_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  localparam logic [32:0] ROM_LO = {1'b0, ROM_BASE_PC};
  localparam logic [32:0] ROM_HI = {1'b0, ROM_BASE_PC} + (33'd4 << ROM_ADDR_WIDTH);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] faddr_q, faddr_d;
  logic [31:0] count_q, count_d;

  logic        accept;
  logic [32:0] cand;
  logic [1:0]  cand_cause;

  // Candidate is kept in 33 bits so a wrapped pc_q+4 lands above ROM_HI.
  function automatic logic [1:0] classify(input logic [32:0] n);
    if (n[1:0] != 2'b00)               return 2'b01;
    else if (n < ROM_LO || n >= ROM_HI) return 2'b10;
    else                                return 2'b00;
  endfunction

  assign accept     = (state_q == RUN) && inst_ready;
  assign cand       = redirect_valid ? {1'b0, redirect_target} : ({1'b0, pc_q} + 33'd4);
  assign cand_cause = classify(cand);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    faddr_d = faddr_q;
    count_d = count_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (accept) count_d = count_q + 32'd1;
        if (redirect_valid || accept) begin
          if (cand_cause != 2'b00) begin
            state_d = FAULT;
            cause_d = cand_cause;
            faddr_d = cand[31:0];
          end else begin
            pc_d = cand[31:0];
          end
        end
      end
      FAULT: begin
        if (redirect_valid) begin
          if (cand_cause == 2'b00) begin
            state_d = RUN;
            pc_d    = cand[31:0];
            cause_d = 2'b00;
          end else begin
            cause_d = cand_cause;
            faddr_d = cand[31:0];
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cause_q <= 2'b00;
      faddr_q <= 32'd0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      faddr_q <= faddr_d;
      count_q <= count_d;
    end
  end

  // Reset forces BOOT, so the enable is gated to keep the ROM idle while reset is held.
  assign imem_en       = !reset && (state_q != FAULT);
  assign imem_addr     = pc_q;
  assign inst_valid    = (state_q == RUN);
  assign inst_out      = inst_valid ? imem_data : 32'd0;
  assign inst_pc       = pc_q;
  assign inst_pc_plus4 = pc_q + 32'd4;
  assign fetch_fault   = (state_q == FAULT);
  assign fault_cause   = cause_q;
  assign fault_addr    = faddr_q;
  assign fetch_count   = count_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: ROM model plus a transaction-level PC/fault reference model,
// directed scenarios followed by randomized ready/redirect traffic and an async reset mid-stall.
module tb_inst_fetch_unit;
  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam longint      BYTES = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = 32'd0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out, inst_pc, inst_pc_plus4;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr, fetch_count;

  inst_fetch_unit dut (
    .clock(clock), .reset(reset),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
    .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .fetch_fault(fetch_fault), .fault_cause(fault_cause), .fault_addr(fault_addr),
    .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  logic [31:0] rom [256];

  always @(negedge clock) begin
    if (imem_en) imem_data <= rom[(imem_addr - BASE) >> 2];
  end

  // Reference model: mode 0 = boot, 1 = running, 2 = faulted.
  int          m_mode;
  longint      m_pc;
  logic [31:0] m_cnt;
  logic [1:0]  m_cause;
  logic [31:0] m_faddr;

  int nvec = 0;
  int nerr = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] addr_cause(input longint n);
    if (n % 4 != 0)                                  return 2'd1;
    if (n < longint'(BASE) || n >= longint'(BASE) + BYTES) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pc = longint'(BASE); m_cnt = 0; m_cause = 0; m_faddr = 0;
  endtask

  task automatic model_step(input bit rdy, input bit rv, input logic [31:0] tgt);
    longint n;
    case (m_mode)
      0: m_mode = 1;
      1: begin
        if (rdy) m_cnt = m_cnt + 1;
        if (rv || rdy) begin
          n = rv ? longint'(tgt) : m_pc + 4;
          if (addr_cause(n) != 0) begin
            m_mode = 2; m_cause = addr_cause(n); m_faddr = n[31:0];
          end else m_pc = n;
        end
      end
      default: begin
        if (rv) begin
          if (addr_cause(longint'(tgt)) == 0) begin
            m_mode = 1; m_pc = longint'(tgt); m_cause = 0;
          end else begin
            m_cause = addr_cause(longint'(tgt)); m_faddr = tgt;
          end
        end
      end
    endcase
  endtask

  task automatic compare_all();
    logic [31:0] pc32;
    pc32 = m_pc[31:0];
    check_eq("imem_en",    32'(imem_en),     32'(m_mode != 2));
    check_eq("imem_addr",  imem_addr,        pc32);
    check_eq("inst_valid", 32'(inst_valid),  32'(m_mode == 1));
    check_eq("inst_out",   inst_out,         (m_mode == 1) ? rom[(pc32 - BASE) >> 2] : 32'd0);
    check_eq("inst_pc",    inst_pc,          pc32);
    check_eq("pc_plus4",   inst_pc_plus4,    pc32 + 32'd4);
    check_eq("fetch_fault",32'(fetch_fault), 32'(m_mode == 2));
    check_eq("fault_cause",32'(fault_cause), 32'(m_cause));
    if (m_mode == 2) check_eq("fault_addr", fault_addr, m_faddr);
    check_eq("fetch_count",fetch_count,      m_cnt);
  endtask

  // Called just after a posedge: drive inputs, check mid-cycle, advance model on the next edge.
  task automatic cycle(input bit rdy, input bit rv, input logic [31:0] tgt);
    inst_ready = rdy; redirect_valid = rv; redirect_target = tgt;
    @(negedge clock); #2;
    compare_all();
    @(posedge clock); #1;
    model_step(rdy, rv, tgt);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_en"},    32'(imem_en),     32'd0);
    check_eq({tag, "_vld"},   32'(inst_valid),  32'd0);
    check_eq({tag, "_out"},   inst_out,         32'd0);
    check_eq({tag, "_pc"},    inst_pc,          BASE);
    check_eq({tag, "_fault"}, 32'(fetch_fault), 32'd0);
    check_eq({tag, "_cause"}, 32'(fault_cause), 32'd0);
    check_eq({tag, "_faddr"}, fault_addr,       32'd0);
    check_eq({tag, "_cnt"},   fetch_count,      32'd0);
  endtask

  logic [31:0] tgt;
  int          pick;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
    model_reset();

    repeat (2) @(posedge clock);
    #1 check_reset_vals("rst");
    reset = 1'b0;

    cycle(1, 0, 0);                         // boot
    repeat (4) cycle(1, 0, 0);              // 0x11..0x44
    check_eq("cnt_after4", fetch_count, 32'd4);

    cycle(0, 1, 32'h0040_0008);
    repeat (3) cycle(0, 0, 0);              // stall at 0x00400008
    check_eq("stall_pc", inst_pc, 32'h0040_0008);
    cycle(1, 0, 0);
    cycle(0, 1, 32'h0040_0020);             // redirect, no accept
    cycle(1, 1, 32'h0040_0020);             // redirect with accept
    cycle(1, 0, 0);
    cycle(0, 1, 32'h0040_0006);             // misaligned
    check_eq("mis_cause", 32'(fault_cause), 32'd1);
    cycle(1, 0, 0);
    cycle(0, 1, 32'h0040_0000);             // exit fault
    cycle(1, 0, 0);
    cycle(0, 1, 32'h0040_03FC);             // last ROM word
    cycle(1, 0, 0);                         // accept, falls off the end
    check_eq("oor_addr", fault_addr, 32'h0040_0400);
    cycle(0, 1, 32'h0030_0000);             // illegal exit attempt
    cycle(0, 1, 32'hFFFF_FFFC);
    cycle(0, 1, 32'h0040_0100);
    cycle(0, 0, 0);

    for (int k = 0; k < 3000; k++) begin
      pick = $urandom_range(0, 9);
      case (pick)
        0:       tgt = BASE + 32'(($urandom_range(0, 255)) * 4) + 32'($urandom_range(1, 3));
        1:       tgt = $urandom;
        2:       tgt = BASE + 32'h3F0 + 32'($urandom_range(0, 3) * 4);
        default: tgt = BASE + 32'(($urandom_range(0, 255)) * 4);
      endcase
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, tgt);
    end

    // Async reset between edges while stalled.
    cycle(0, 1, 32'h0040_0040);
    inst_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge clock); #1 reset = 1'b1;
    #1 check_reset_vals("arst");
    @(posedge clock); #1 reset = 1'b0;
    model_reset();
    for (int k = 0; k < 200; k++)
      cycle($urandom_range(0, 1), $urandom_range(0, 9) == 0, BASE + 32'(($urandom_range(0, 300)) * 4));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
